// File: rtl/md_stall_ctrl.sv
// md_stall_ctrl: HI/LO hazard and stall controller placed in front of the
// multiply/divide unit. It decodes the D-stage instruction, runs a busy
// countdown for issued mult/div operations, and merges its own hold with the
// register-file data-hazard stall. stall_d and bubble_e are combinational so
// that the front end freezes in the same cycle the hazard is seen.
// Optional build macro: MD_STALL_CNT_EN adds the md_stall_cycles counter.
module md_stall_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      d_instr,
    input  logic             d_valid,
    input  logic             ext_stall,
    output logic             stall_d,
    output logic             bubble_e,
    output logic             md_busy,
    output logic [CNT_W-1:0] md_cnt
`ifdef MD_STALL_CNT_EN
    ,
    output logic [31:0]      md_stall_cycles
`endif
);

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI     = 6'h10;
    localparam logic [5:0] FN_MTHI     = 6'h11;
    localparam logic [5:0] FN_MFLO     = 6'h12;
    localparam logic [5:0] FN_MTLO     = 6'h13;
    localparam logic [5:0] FN_MULT     = 6'h18;
    localparam logic [5:0] FN_MULTU    = 6'h19;
    localparam logic [5:0] FN_DIV      = 6'h1A;
    localparam logic [5:0] FN_DIVU     = 6'h1B;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_MUL,
        CLS_DIV,
        CLS_MOV
    } md_class_t;

    typedef enum logic {
        IDLE,
        BUSY
    } md_state_t;

    md_class_t        cls;
    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             md_hold;
    logic             issue_mul;
    logic             issue_div;
    logic             unused_instr;

    // Only opcode and funct matter for HI/LO classification.
    assign unused_instr = ^d_instr[25:6];

    // Classify the D-stage instruction; bubbles never count as HI/LO users.
    always_comb begin
        cls = CLS_NONE;
        if (d_valid && (d_instr[31:26] == OPC_SPECIAL)) begin
            case (d_instr[5:0])
                FN_MULT, FN_MULTU:                   cls = CLS_MUL;
                FN_DIV, FN_DIVU:                     cls = CLS_DIV;
                FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO:  cls = CLS_MOV;
                default:                             cls = CLS_NONE;
            endcase
        end
    end

    // Hold any HI/LO user while the unit is busy; merge with the data-hazard stall.
    always_comb begin
        md_hold   = (cls != CLS_NONE) && (state == BUSY);
        stall_d   = md_hold || ext_stall;
        bubble_e  = stall_d;
        issue_mul = (cls == CLS_MUL) && !stall_d;
        issue_div = (cls == CLS_DIV) && !stall_d;
    end

    assign md_busy = (state == BUSY);
    assign md_cnt  = cnt;

    // Busy countdown: load on issue, otherwise count down to zero and idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= CNT_ZERO;
        end else if (issue_mul) begin
            state <= (MULT_LOAD != CNT_ZERO) ? BUSY : IDLE;
            cnt   <= MULT_LOAD;
        end else if (issue_div) begin
            state <= (DIV_LOAD != CNT_ZERO) ? BUSY : IDLE;
            cnt   <= DIV_LOAD;
        end else if (state == BUSY) begin
            if (cnt <= CNT_ONE) begin
                state <= IDLE;
                cnt   <= CNT_ZERO;
            end else begin
                cnt   <= cnt - CNT_ONE;
            end
        end
    end

`ifdef MD_STALL_CNT_EN
    // Count cycles lost to HI/LO holds only; data-hazard-only stalls are excluded.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_stall_cycles <= 32'd0;
        end else if (md_hold) begin
            md_stall_cycles <= md_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Bench for md_stall_ctrl: directed vector table, hand-written multi-cycle
// sequences, and a randomized run against a busy-until-cycle reference model.
module tb_md_stall_ctrl;

    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;
    localparam int unsigned CNT_W    = 4;

    localparam logic [31:0] I_NOP   = 32'h0000_0000;
    localparam logic [31:0] I_MULT  = 32'h0085_1018;
    localparam logic [31:0] I_DIV   = 32'h0085_101A;
    localparam logic [31:0] I_ADDU  = 32'h0085_1021;
    localparam logic [31:0] I_MFHI  = 32'h0000_4010;
    localparam logic [31:0] I_MFLO  = 32'h0000_4012;
    localparam logic [31:0] I_MTHI  = 32'h0080_0011;
    localparam logic [31:0] I_LWF18 = 32'h8C00_0018;

    logic             clk;
    logic             reset;
    logic [31:0]      d_instr;
    logic             d_valid;
    logic             ext_stall;
    logic             stall_d;
    logic             bubble_e;
    logic             md_busy;
    logic [CNT_W-1:0] md_cnt;
`ifdef MD_STALL_CNT_EN
    logic [31:0]      md_stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    md_stall_ctrl #(
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .d_instr  (d_instr),
        .d_valid  (d_valid),
        .ext_stall(ext_stall),
        .stall_d  (stall_d),
        .bubble_e (bubble_e),
        .md_busy  (md_busy),
        .md_cnt   (md_cnt)
`ifdef MD_STALL_CNT_EN
        ,
        .md_stall_cycles(md_stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        ext;
        logic        rst;
        logic        exp_stall;
        int          exp_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge; outputs are stable #1 later.
    task automatic drive(input logic [31:0] instr, input logic v, input logic e, input logic r);
        @(negedge clk);
        cyc++;
        d_instr   = instr;
        d_valid   = v;
        ext_stall = e;
        reset     = r;
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic exp_stall, input int exp_cnt);
        chk({tag, ".stall_d"},  32'(stall_d),  32'(exp_stall));
        chk({tag, ".bubble_e"}, 32'(bubble_e), 32'(exp_stall));
        chk({tag, ".md_busy"},  32'(md_busy),  32'(exp_cnt != 0));
        chk({tag, ".md_cnt"},   32'(md_cnt),   32'(exp_cnt));
    endtask

    // Reference classification: 0 none, 1 mul, 2 div, 3 HI/LO move.
    function automatic int ref_class(input logic [31:0] ins, input logic v);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (!v || op != 6'h00) return 0;
        if (fn == 6'h18 || fn == 6'h19) return 1;
        if (fn == 6'h1A || fn == 6'h1B) return 2;
        if (fn >= 6'h10 && fn <= 6'h13) return 3;
        return 0;
    endfunction

    vec_t tbl[$];
    logic [31:0] pool[10];

    initial begin
        int busy_end;
        int rc;
        int rem;
        logic exp_st;
        logic [31:0] ins;
        logic v, e, r;
`ifdef MD_STALL_CNT_EN
        logic [31:0] snap;
        int hold_cnt;
`endif
        d_instr   = I_NOP;
        d_valid   = 1'b0;
        ext_stall = 1'b0;
        reset     = 1'b1;

        // Directed table: expectations are the values seen in that cycle, before the edge.
        tbl.push_back('{I_MULT,  1'b1, 1'b0, 1'b0, 1'b0, 0});
        tbl.push_back('{I_NOP,   1'b1, 1'b0, 1'b0, 1'b0, 5});
        tbl.push_back('{I_ADDU,  1'b1, 1'b0, 1'b0, 1'b0, 4});
        tbl.push_back('{I_ADDU,  1'b1, 1'b0, 1'b0, 1'b0, 3});
        tbl.push_back('{I_ADDU,  1'b1, 1'b1, 1'b0, 1'b1, 2});
        tbl.push_back('{I_MFHI,  1'b1, 1'b0, 1'b0, 1'b1, 1});
        tbl.push_back('{I_MFHI,  1'b1, 1'b0, 1'b0, 1'b0, 0});
        tbl.push_back('{I_DIV,   1'b1, 1'b1, 1'b0, 1'b1, 0});
        tbl.push_back('{I_DIV,   1'b1, 1'b1, 1'b0, 1'b1, 0});
        tbl.push_back('{I_DIV,   1'b1, 1'b0, 1'b0, 1'b0, 0});
        tbl.push_back('{I_NOP,   1'b1, 1'b0, 1'b0, 1'b0, 10});
        tbl.push_back('{I_MFLO,  1'b0, 1'b0, 1'b0, 1'b0, 9});
        tbl.push_back('{I_MTHI,  1'b1, 1'b0, 1'b0, 1'b1, 8});
        tbl.push_back('{I_LWF18, 1'b1, 1'b0, 1'b0, 1'b0, 7});
        tbl.push_back('{I_NOP,   1'b1, 1'b0, 1'b1, 1'b0, 6});
        tbl.push_back('{I_MFHI,  1'b1, 1'b0, 1'b0, 1'b0, 0});
        tbl.push_back('{I_MFHI,  1'b1, 1'b1, 1'b0, 1'b1, 0});

        // Reset and confirm the idle state.
        drive(I_NOP, 1'b0, 1'b0, 1'b1);
        drive(I_NOP, 1'b0, 1'b1, 1'b1);
        chk_outs("reset", 1'b1, 0);
        drive(I_MFHI, 1'b1, 1'b0, 1'b1);
        chk_outs("reset_idle", 1'b0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].instr, tbl[i].valid, tbl[i].ext, tbl[i].rst);
            chk_outs($sformatf("vec%0d", i), tbl[i].exp_stall, tbl[i].exp_cnt);
        end

        // div, then mflo arriving the next cycle: held for exactly DIV_LAT cycles.
        drive(I_DIV, 1'b1, 1'b0, 1'b0);
        chk_outs("divmflo_issue", 1'b0, 0);
        for (int i = 0; i < int'(DIV_LAT); i++) begin
            drive(I_MFLO, 1'b1, 1'b0, 1'b0);
            chk_outs($sformatf("divmflo_hold%0d", i), 1'b1, int'(DIV_LAT) - i);
        end
        drive(I_MFLO, 1'b1, 1'b0, 1'b0);
        chk_outs("divmflo_release", 1'b0, 0);

`ifdef MD_STALL_CNT_EN
        // mult then mfhi held in D: stall counter advances by MULT_LAT.
        drive(I_MULT, 1'b1, 1'b0, 1'b0);
        snap = md_stall_cycles;
        for (int i = 0; i < int'(MULT_LAT); i++) begin
            drive(I_MFHI, 1'b1, 1'b0, 1'b0);
            chk_outs($sformatf("cnt_hold%0d", i), 1'b1, int'(MULT_LAT) - i);
        end
        drive(I_MFHI, 1'b1, 1'b0, 1'b0);
        chk("stall_cycles_mult", md_stall_cycles - snap, 32'(MULT_LAT));
        snap = md_stall_cycles;
        for (int i = 0; i < 3; i++) drive(I_ADDU, 1'b1, 1'b1, 1'b0);
        drive(I_NOP, 1'b1, 1'b0, 1'b0);
        chk("stall_cycles_ext_only", md_stall_cycles, snap);
        drive(I_NOP, 1'b1, 1'b0, 1'b1);
        drive(I_NOP, 1'b1, 1'b0, 1'b0);
        chk("stall_cycles_reset", md_stall_cycles, 32'd0);
        hold_cnt = 0;
`endif

        // Randomized run against a model that tracks the cycle at which the unit frees up.
        pool[0] = I_MULT;  pool[1] = 32'h0085_1019;
        pool[2] = I_DIV;   pool[3] = 32'h0085_101B;
        pool[4] = I_MFHI;  pool[5] = I_MFLO;
        pool[6] = I_MTHI;  pool[7] = 32'h0080_0013;
        pool[8] = I_ADDU;  pool[9] = I_LWF18;

        drive(I_NOP, 1'b0, 1'b0, 1'b1);
        busy_end = 0;
        for (int n = 0; n < 3000; n++) begin
            rc = int'($urandom_range(0, 10));
            ins = (rc == 10) ? 32'($urandom) : pool[rc];
            v = ($urandom_range(0, 9) != 0);
            e = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 59) == 0);
            drive(ins, v, e, r);
            rem = (busy_end > cyc) ? busy_end - cyc : 0;
            rc = ref_class(ins, v);
            exp_st = ((rc != 0) && (rem > 0)) || e;
            chk_outs("rand", exp_st, rem);
`ifdef MD_STALL_CNT_EN
            chk("rand.stall_cycles", md_stall_cycles, 32'(hold_cnt));
            if (r) hold_cnt = 0;
            else if ((rc != 0) && (rem > 0)) hold_cnt++;
`endif
            if (r) busy_end = 0;
            else if (!exp_st && rc == 1) busy_end = cyc + 1 + int'(MULT_LAT);
            else if (!exp_st && rc == 2) busy_end = cyc + 1 + int'(DIV_LAT);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
